// File: rtl/psum_accum_ctrl_if.sv
// ---------------------------------------------------------------------------
// psum_accum_ctrl_if
//   Bundles the three buses of the psum accumulation controller:
//     - psum input stream  : i_psum_valid / i_psum_data / o_psum_ready
//     - result stream      : o_out_valid / o_out_data / i_out_ready
//     - psum memory port   : o_mem_wr_* (write), o_mem_rd_* (read, 1-cycle
//                            latency), i_mem_rd_data
//   master : the controller's view (drives o_*, samples i_*)
//   slave  : the environment's view (PE array, result sink, memory)
// ---------------------------------------------------------------------------
interface psum_accum_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  i_psum_valid;
   logic [DATA_WIDTH-1:0] i_psum_data;
   logic                  o_psum_ready;

   logic                  o_out_valid;
   logic [DATA_WIDTH-1:0] o_out_data;
   logic                  i_out_ready;

   logic                  o_mem_wr_en;
   logic [ADDR_WIDTH-1:0] o_mem_wr_addr;
   logic [DATA_WIDTH-1:0] o_mem_wr_data;
   logic                  o_mem_rd_en;
   logic [ADDR_WIDTH-1:0] o_mem_rd_addr;
   logic [DATA_WIDTH-1:0] i_mem_rd_data;

   modport master (
      input  i_psum_valid, i_psum_data, i_out_ready, i_mem_rd_data,
      output o_psum_ready, o_out_valid, o_out_data,
             o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data,
             o_mem_rd_en, o_mem_rd_addr
   );

   modport slave (
      output i_psum_valid, i_psum_data, i_out_ready, i_mem_rd_data,
      input  o_psum_ready, o_out_valid, o_out_data,
             o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data,
             o_mem_rd_en, o_mem_rd_addr
   );
endinterface

// File: rtl/psum_accum_ctrl.sv
// ---------------------------------------------------------------------------
// psum_accum_ctrl
//   Accumulates a stream of partial sums into the psum memory by
//   read-modify-write over a configurable number of passes, then optionally
//   drains the final sums as a valid/ready stream.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           job start pulse (sampled in IDLE only)
//   i_base_addr       first memory address of the job
//   i_len             entries per pass (0 = empty job)
//   i_num_pass        number of passes (0 behaves as 1)
//   i_drain_en        stream results out after the last pass
//   o_busy            high whenever not IDLE
//   o_done            one-cycle pulse at job completion
//   bus               psum stream, result stream and memory port
// ---------------------------------------------------------------------------
module psum_accum_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int PASS_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH-1:0] i_len,
   input  logic [PASS_WIDTH-1:0] i_num_pass,
   input  logic                  i_drain_en,
   output logic                  o_busy,
   output logic                  o_done,
   psum_accum_ctrl_if.master     bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

   localparam logic [DATA_WIDTH-1:0] SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
   localparam logic [PASS_WIDTH-1:0] P_ONE    = PASS_WIDTH'(1);

   state_t                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]       base_q, base_d, len_q, len_d;
   logic [PASS_WIDTH-1:0]       npass_q, npass_d, pass_q, pass_d;
   logic                        drain_q, drain_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d, idx_q, idx_d;
   logic                        fin_q, fin_d;
   // write stage: one cycle behind the psum handshake
   logic                        wr_pend_q, wr_pend_d, rmw_q, rmw_d;
   logic [ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]       psum_q, psum_d;
   // read/write same-address bypass (len=1 accumulation)
   logic                        byp_q, byp_d;
   logic [DATA_WIDTH-1:0]       byp_data_q, byp_data_d;
   // drain
   logic [ADDR_WIDTH-1:0]       drd_addr_q, drd_addr_d, drd_cnt_q, drd_cnt_d;
   logic [ADDR_WIDTH-1:0]       out_cnt_q, out_cnt_d;
   logic                        rd_infl_q, rd_infl_d;
   logic [1:0][DATA_WIDTH-1:0]  fifo_q, fifo_d;
   logic                        fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
   logic [1:0]                  fifo_cnt_q, fifo_cnt_d;
   logic                        done_q, done_d;

   logic [DATA_WIDTH-1:0]       rd_data_eff, wr_data;
   logic                        acc_hs, acc_rd, drain_rd, pop;
   logic [2:0]                  occ;

   function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH:0] s;
      s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      // top two bits disagree -> result left the DATA_WIDTH signed range
      if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) sat_add = s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
      else                                  sat_add = s[DATA_WIDTH-1:0];
   endfunction

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      npass_d    = npass_q;
      drain_d    = drain_q;
      addr_d     = addr_q;
      idx_d      = idx_q;
      pass_d     = pass_q;
      fin_d      = fin_q;
      wr_pend_d  = 1'b0;
      rmw_d      = rmw_q;
      wr_addr_d  = wr_addr_q;
      psum_d     = psum_q;
      drd_addr_d = drd_addr_q;
      drd_cnt_d  = drd_cnt_q;
      out_cnt_d  = out_cnt_q;
      fifo_d     = fifo_q;
      fifo_wp_d  = fifo_wp_q;
      fifo_rp_d  = fifo_rp_q;
      done_d     = (state_q == S_DONE);

      rd_data_eff = byp_q ? byp_data_q : bus.i_mem_rd_data;
      wr_data     = rmw_q ? sat_add(rd_data_eff, psum_q) : psum_q;
      pop         = (fifo_cnt_q != 2'd0) && bus.i_out_ready;
      occ         = {1'b0, fifo_cnt_q} + {2'b00, rd_infl_q};
      acc_hs      = (state_q == S_ACC) && !fin_q && bus.i_psum_valid;
      acc_rd      = acc_hs && (pass_q != '0);
      // credit: buffered + in flight - leaving this cycle must stay below 2
      drain_rd    = (state_q == S_DRAIN) && (drd_cnt_q != len_q) &&
                    (occ < (pop ? 3'd3 : 3'd2));

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               base_d     = i_base_addr;
               len_d      = i_len;
               npass_d    = (i_num_pass == '0) ? P_ONE : i_num_pass;
               drain_d    = i_drain_en;
               addr_d     = i_base_addr;
               idx_d      = '0;
               pass_d     = '0;
               fin_d      = 1'b0;
               drd_addr_d = i_base_addr;
               drd_cnt_d  = '0;
               out_cnt_d  = '0;
               state_d    = (i_len == '0) ? S_DONE : S_ACC;
            end
         end
         S_ACC: begin
            if (acc_hs) begin
               wr_pend_d = 1'b1;
               wr_addr_d = addr_q;
               psum_d    = bus.i_psum_data;
               rmw_d     = (pass_q != '0);
               if (idx_q == len_q - A_ONE) begin
                  idx_d  = '0;
                  addr_d = base_q;
                  pass_d = pass_q + P_ONE;
                  if (pass_q == npass_q - P_ONE) fin_d = 1'b1;
               end else begin
                  idx_d  = idx_q + A_ONE;
                  addr_d = addr_q + A_ONE;
               end
            end
            // fin_q is set: the final write is on the port this cycle
            if (fin_q) state_d = drain_q ? S_DRAIN : S_DONE;
         end
         S_DRAIN: begin
            if (drain_rd) begin
               drd_addr_d = drd_addr_q + A_ONE;
               drd_cnt_d  = drd_cnt_q + A_ONE;
            end
            if (pop) begin
               out_cnt_d = out_cnt_q + A_ONE;
               if (out_cnt_q == len_q - A_ONE) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      rd_infl_d  = drain_rd;
      byp_d      = acc_rd && wr_pend_q && (addr_q == wr_addr_q);
      byp_data_d = wr_data;

      if (rd_infl_q) begin
         fifo_d[fifo_wp_q] = bus.i_mem_rd_data;
         fifo_wp_d         = ~fifo_wp_q;
      end
      if (pop) fifo_rp_d = ~fifo_rp_q;
      fifo_cnt_d = fifo_cnt_q + {1'b0, rd_infl_q} - {1'b0, pop};

      bus.o_psum_ready  = (state_q == S_ACC) && !fin_q;
      bus.o_mem_rd_en   = acc_rd || drain_rd;
      bus.o_mem_rd_addr = acc_rd ? addr_q : (drain_rd ? drd_addr_q : '0);
      bus.o_mem_wr_en   = wr_pend_q;
      bus.o_mem_wr_addr = wr_pend_q ? wr_addr_q : '0;
      bus.o_mem_wr_data = wr_pend_q ? wr_data : '0;
      bus.o_out_valid   = (fifo_cnt_q != 2'd0);
      bus.o_out_data    = fifo_q[fifo_rp_q];
      o_busy            = (state_q != S_IDLE);
      o_done            = done_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         npass_q    <= '0;
         drain_q    <= 1'b0;
         addr_q     <= '0;
         idx_q      <= '0;
         pass_q     <= '0;
         fin_q      <= 1'b0;
         wr_pend_q  <= 1'b0;
         rmw_q      <= 1'b0;
         wr_addr_q  <= '0;
         psum_q     <= '0;
         byp_q      <= 1'b0;
         byp_data_q <= '0;
         drd_addr_q <= '0;
         drd_cnt_q  <= '0;
         out_cnt_q  <= '0;
         rd_infl_q  <= 1'b0;
         fifo_q     <= '0;
         fifo_wp_q  <= 1'b0;
         fifo_rp_q  <= 1'b0;
         fifo_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         npass_q    <= npass_d;
         drain_q    <= drain_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         pass_q     <= pass_d;
         fin_q      <= fin_d;
         wr_pend_q  <= wr_pend_d;
         rmw_q      <= rmw_d;
         wr_addr_q  <= wr_addr_d;
         psum_q     <= psum_d;
         byp_q      <= byp_d;
         byp_data_q <= byp_data_d;
         drd_addr_q <= drd_addr_d;
         drd_cnt_q  <= drd_cnt_d;
         out_cnt_q  <= out_cnt_d;
         rd_infl_q  <= rd_infl_d;
         fifo_q     <= fifo_d;
         fifo_wp_q  <= fifo_wp_d;
         fifo_rp_q  <= fifo_rp_d;
         fifo_cnt_q <= fifo_cnt_d;
         done_q     <= done_d;
      end
   end
endmodule
